cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
Synthesizable run controller and result checker for CPU regression runs. It sequences the CPU reset (low window, then high window, then release) and then watches the CPU result buses `sum` and `q` until they hold the expected values or a cycle budget runs out. It replaces hand-timed reset waveforms, and lets regression benches and on-board self-test report pass/fail without waveform inspection.

Parameters:
DATA_W, 32, width of the `sum`, `q` and expected-value buses
PRE_RST_CYC, 8, cycles `cpu_rst` is held low before the reset pulse; 0 is legal and skips the PRE state
RST_CYC, 8, cycles `cpu_rst` is held high; minimum 1
STABLE_CYC, 4, consecutive matching cycles required to declare pass; minimum 1
TIMEOUT, 1024, maximum RUN cycles before declaring fail
CNT_W, $clog2(TIMEOUT+1), width of `cycle_count`

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset of this block
start  in  1  one-cycle request to begin a run
exp_sum  in  DATA_W  expected final `sum`; sampled on accepted `start`
exp_q  in  DATA_W  expected final `q`; sampled on accepted `start`
sum  in  DATA_W  CPU `sum` output under observation
q  in  DATA_W  CPU `q` output under observation
cpu_rst  out  1  generated active-high reset to the CPU
busy  out  1  high in PRE, RESET and RUN
done  out  1  high in PASS or FAIL
pass  out  1  high only in PASS
cycle_count  out  CNT_W  RUN cycles elapsed; frozen in PASS/FAIL

Behaviour:
- Reset values (`rst` high, asynchronous):
  - state = IDLE, `cpu_rst` = 1, `busy` = 0, `done` = 0, `pass` = 0, `cycle_count` = 0.
  - Internal phase and stable counters = 0; latched expected values = 0.
- All outputs are registered. `cpu_rst` is a pure function of the registered state: 1 in IDLE and RESET, 0 in PRE, RUN, PASS and FAIL.
- `start` is accepted in IDLE, PASS or FAIL; it is ignored while `busy`. On acceptance:
  - `exp_sum` and `exp_q` are latched.
  - `cycle_count` and all counters clear.
  - `done` and `pass` drop on the next edge.
- State transitions:
  - IDLE -> PRE on `start`, or -> RESET directly if PRE_RST_CYC = 0.
  - PRE: stays exactly PRE_RST_CYC cycles, then -> RESET.
  - RESET: stays exactly RST_CYC cycles, then -> RUN.
  - RUN:
    - `cycle_count` is 0 in the first RUN cycle and increments by 1 each cycle.
    - Match = (`sum` == latched exp_sum) && (`q` == latched exp_q).
    - Stable counter increments on match and clears to 0 on mismatch.
    - -> PASS in the cycle the stable counter reaches STABLE_CYC.
    - -> FAIL in the cycle `cycle_count` reaches TIMEOUT-1 without a pass.
    - If both conditions occur in the same cycle, PASS wins.
  - PASS / FAIL: hold; `cpu_rst` stays 0 so the CPU state remains observable; restart on `start`.
- `cycle_count` saturates at TIMEOUT-1 and never wraps.
- Asserting `rst` mid-run immediately forces IDLE and `cpu_rst` = 1, regardless of state.
- `sum` and `q` are compared unregistered. The CPU is on the same `clk` domain; no CDC logic.

Optional Feature:
Macro: `CPU_RUN_MONITOR_TRACE_EN`.
- Defined:
  - Adds output port `change_count` [15:0]: number of RUN cycles in which `sum` differs from its value in the previous cycle.
  - The first RUN cycle is not counted.
  - Saturates at 16'hFFFF; clears on accepted `start` and on `rst`.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. `rst` pulse, then idle 20 cycles -> `cpu_rst` = 1, `busy` = 0, `done` = 0, `pass` = 0, `cycle_count` = 0 throughout.
2. PRE_RST_CYC = 8, RST_CYC = 8, `start` at cycle 0 -> `cpu_rst` low for cycles 1-8, high for cycles 9-16, low from cycle 17; `busy` high from cycle 1.
3. exp_sum = 32'd55, exp_q = 32'd10; model drives `sum` = 55, `q` = 10 from RUN cycle 30 on -> PASS entered at RUN cycle 33, `pass` = 1, `done` = 1, `cycle_count` = 33 frozen.
4. Model matches for 3 cycles, breaks for 1 cycle, then matches steadily from RUN cycle 50 -> no pass before RUN cycle 53; PASS at 53.
5. TIMEOUT = 64, `sum` never matches -> FAIL at RUN cycle 63, `done` = 1, `pass` = 0, `cycle_count` = 63.
6. Assert `rst` during RESET and during RUN -> same cycle `cpu_rst` = 1, `busy` = 0. A following `start` reruns the full sequence. With TRACE_EN defined and `sum` incrementing 0..9 -> `change_count` = 9.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// CPU run controller: sequences CPU reset (PRE low, RESET high), then
// watches sum/q for a stable match against latched expected values or a
// cycle budget, reporting pass/fail.
// Ports: clk, rst (async, active high), start, exp_sum, exp_q, sum, q in;
//        cpu_rst, busy, done, pass, cycle_count out.
// Option: CPU_RUN_MONITOR_TRACE_EN adds change_count (sum changes in RUN).
module cpu_run_monitor #(
  parameter int DATA_W      = 32,
  parameter int PRE_RST_CYC = 8,
  parameter int RST_CYC     = 8,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = $clog2(TIMEOUT+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] exp_sum,
  input  logic [DATA_W-1:0] exp_q,
  input  logic [DATA_W-1:0] sum,
  input  logic [DATA_W-1:0] q,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  cycle_count
`ifdef CPU_RUN_MONITOR_TRACE_EN
  ,
  output logic [15:0]       change_count
`endif
);

  localparam int PH_MAX =
    (PRE_RST_CYC > RST_CYC) ? PRE_RST_CYC : RST_CYC;
  localparam int PH_W = $clog2(PH_MAX + 1);
  localparam int ST_W = $clog2(STABLE_CYC + 1);

  localparam logic [PH_W-1:0] PRE_LAST =
    PH_W'(PRE_RST_CYC - 1);
  localparam logic [PH_W-1:0] RST_LAST =
    PH_W'(RST_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST =
    ST_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_RESET, S_RUN, S_PASS, S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ST_W-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] es_q, es_d;
  logic [DATA_W-1:0] eq_q, eq_d;
  logic              cpu_rst_q, busy_q;
  logic              done_q, pass_q;
  logic              match;
  logic              start_ok;

  assign match = (sum == es_q) && (q == eq_q);
  assign start_ok = start &&
    ((state_q == S_IDLE) || (state_q == S_PASS) ||
     (state_q == S_FAIL));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    es_d     = es_q;
    eq_d     = eq_q;
    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start_ok) begin
          es_d     = exp_sum;
          eq_d     = exp_q;
          phase_d  = '0;
          stable_d = '0;
          cnt_d    = '0;
          state_d  = (PRE_RST_CYC == 0) ? S_RESET : S_PRE;
        end
      end
      S_PRE: begin
        if (phase_q == PRE_LAST) begin
          phase_d = '0;
          state_d = S_RESET;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_RESET: begin
        if (phase_q == RST_LAST) begin
          phase_d = '0;
          state_d = S_RUN;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_RUN: begin
        stable_d = match ? stable_q + 1'b1 : '0;
        // pass has priority over timeout in the same cycle;
        // cycle_count freezes on the exit edge
        if (match && (stable_q == ST_LAST)) begin
          state_d = S_PASS;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      es_q      <= '0;
      eq_q      <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      es_q      <= es_d;
      eq_q      <= eq_d;
      cpu_rst_q <= (state_d == S_IDLE) ||
                   (state_d == S_RESET);
      busy_q    <= (state_d == S_PRE) ||
                   (state_d == S_RESET) ||
                   (state_d == S_RUN);
      done_q    <= (state_d == S_PASS) ||
                   (state_d == S_FAIL);
      pass_q    <= (state_d == S_PASS);
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign cycle_count = cnt_q;

`ifdef CPU_RUN_MONITOR_TRACE_EN
  logic [DATA_W-1:0] prev_q;
  logic [15:0]       chg_q;

  // cnt_q is zero only in the first RUN cycle, which is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      chg_q  <= '0;
    end else begin
      prev_q <= sum;
      if (start_ok) begin
        chg_q <= '0;
      end else if ((state_q == S_RUN) && (cnt_q != '0) &&
                   (sum != prev_q) && (chg_q != 16'hFFFF)) begin
        chg_q <= chg_q + 16'd1;
      end
    end
  end

  assign change_count = chg_q;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: table vectors, hand sequences and
// randomized runs against a window-based reference model.
module tb_cpu_run_monitor;

  localparam int PRE  = 8;
  localparam int RSTC = 8;
  localparam int STB  = 4;
  localparam int TO   = 64;
  localparam int CW   = $clog2(TO + 1);
  localparam int RUN0 = PRE + RSTC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] exp_sum, exp_q, sum, q;
  wire         cpu_rst, busy, done, pass;
  wire [CW-1:0] cycle_count;
  wire         z_cpu_rst, z_busy, z_done, z_pass;
  wire [2:0]   z_cc;
`ifdef CPU_RUN_MONITOR_TRACE_EN
  wire [15:0]  change_count;
  wire [15:0]  z_chg;
`endif

  cpu_run_monitor #(
    .DATA_W(32), .PRE_RST_CYC(PRE), .RST_CYC(RSTC),
    .STABLE_CYC(STB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .exp_sum(exp_sum), .exp_q(exp_q),
    .sum(sum), .q(q),
    .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .pass(pass), .cycle_count(cycle_count)
`ifdef CPU_RUN_MONITOR_TRACE_EN
    , .change_count(change_count)
`endif
  );

  cpu_run_monitor #(
    .DATA_W(32), .PRE_RST_CYC(0), .RST_CYC(2),
    .STABLE_CYC(1), .TIMEOUT(4)
  ) dutz (
    .clk(clk), .rst(rst), .start(start),
    .exp_sum(exp_sum), .exp_q(exp_q),
    .sum(sum), .q(q),
    .cpu_rst(z_cpu_rst), .busy(z_busy), .done(z_done),
    .pass(z_pass), .cycle_count(z_cc)
`ifdef CPU_RUN_MONITOR_TRACE_EN
    , .change_count(z_chg)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  bit          mt [0:TO-1];
  bit          ramp = 1'b0;
  logic [31:0] es, eq;
  int          m_end;
  bit          m_pass;

  // pass at the first run cycle closing a window of STB matches;
  // otherwise fail at the last budgeted cycle
  function automatic void model();
    bit ok;
    m_pass = 1'b0;
    m_end  = TO - 1;
    for (int r = STB - 1; r < TO; r++) begin
      ok = 1'b1;
      for (int j = 0; j < STB; j++)
        if (!mt[r-j]) ok = 1'b0;
      if (ok) begin
        m_pass = 1'b1;
        m_end  = r;
        break;
      end
    end
  endfunction

  task automatic run(input string nm, input bit noisy);
    int r;
    logic [1:0]    mis;
    logic [CW+3:0] e;
    model();
    @(posedge clk); #1;
    exp_sum = es;
    exp_q   = eq;
    start   = 1'b1;
    for (int k = 1; k <= RUN0 + m_end + 3; k++) begin
      @(posedge clk); #1;
      r = k - RUN0;
      start = noisy && (k <= RUN0 + m_end - 1 + 1) &&
              ($urandom_range(0, 5) == 0);
      if (noisy) begin
        exp_sum = $urandom;
        exp_q   = $urandom;
      end
      if (ramp) begin
        sum = (r < 0) ? $urandom : ((r > 9) ? 32'd9 : 32'(r));
        q   = eq;
      end else if (r >= 0 && r < TO && mt[r]) begin
        sum = es;
        q   = eq;
      end else begin
        mis = 2'($urandom_range(1, 3));
        sum = es ^ (mis[0] ? ($urandom | 32'd1) : 32'd0);
        q   = eq ^ (mis[1] ? ($urandom | 32'd1) : 32'd0);
      end
      if (k <= PRE)
        e = {4'b0100, CW'(0)};
      else if (k <= PRE + RSTC)
        e = {4'b1100, CW'(0)};
      else if (r <= m_end)
        e = {4'b0100, CW'(r)};
      else
        e = {3'b001, m_pass, CW'(m_end)};
      chk($sformatf("%s k%0d outs", nm, k),
          {cpu_rst, busy, done, pass, cycle_count}, e);
    end
    start = 1'b0;
  endtask

  typedef struct {
    string nm;
    int    lo;
    int    hi;
    int    steady;
    bit    p;
    int    cnt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{"t3_pass33", 1, 0, 30, 1'b1, 33};
    tbl[1] = '{"t4_glitch", 46, 48, 50, 1'b1, 53};
    tbl[2] = '{"t5_never", 1, 0, 1000, 1'b0, 63};
    tbl[3] = '{"immediate", 1, 0, 0, 1'b1, 3};
    tbl[4] = '{"pass_wins", 1, 0, 60, 1'b1, 63};
    tbl[5] = '{"late_fail", 1, 0, 61, 1'b0, 63};
    tbl[6] = '{"three_only", 10, 12, 1000, 1'b0, 63};

    rst = 1'b1; start = 1'b0;
    exp_sum = '0; exp_q = '0; sum = '0; q = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle c%0d", i),
          {cpu_rst, busy, done, pass, cycle_count},
          {4'b1000, CW'(0)});
    end
    chk("z idle", {z_cpu_rst, z_busy, z_done, z_pass}, 4'b1000);

    // zero-length PRE on dutz, then reset main dut in RESET
    @(posedge clk); #1;
    start = 1'b1;
    sum = 32'hdead_0001;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k <= 2)
        chk($sformatf("z k%0d", k), {z_cpu_rst, z_busy}, 2'b11);
      if (k == 3)
        chk("z run k3", {z_cpu_rst, z_busy}, 2'b01);
      if (k == 1)
        chk("pre k1", {cpu_rst, busy, done}, 3'b010);
    end
    chk("reset phase", {cpu_rst, busy}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst in RESET", {cpu_rst, busy, done, pass},
           4'b1000);
    @(posedge clk); #3 rst = 1'b0;

    foreach (tbl[i]) begin
      es = (i == 0) ? 32'd55 : $urandom;
      eq = (i == 0) ? 32'd10 : $urandom;
      for (int r = 0; r < TO; r++)
        mt[r] = (r >= tbl[i].lo && r <= tbl[i].hi) ||
                (r >= tbl[i].steady);
      run(tbl[i].nm, 1'b0);
      chk({tbl[i].nm, " done"}, done, 1'b1);
      chk({tbl[i].nm, " pass"}, pass, tbl[i].p);
      chk({tbl[i].nm, " cnt"}, cycle_count, tbl[i].cnt);
    end

    // reset while in RUN, from a finished state
    @(posedge clk); #1;
    start = 1'b1;
    sum = 32'h1; q = 32'h2;
    exp_sum = 32'h3; exp_q = 32'h4;
    for (int k = 1; k <= RUN0 + 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("run before rst", {busy, cycle_count},
        {1'b1, CW'(20)});
    #2 rst = 1'b1;
    #1 chk("rst in RUN", {cpu_rst, busy, done, pass, cycle_count},
           {4'b1000, CW'(0)});
    @(posedge clk); #3 rst = 1'b0;

    for (int n = 0; n < 6; n++) begin
      int p;
      p  = $urandom_range(50, 97);
      es = $urandom;
      eq = $urandom;
      for (int r = 0; r < TO; r++)
        mt[r] = ($urandom_range(0, 99) < p);
      run($sformatf("rnd%0d", n), 1'b1);
    end

`ifdef CPU_RUN_MONITOR_TRACE_EN
    ramp = 1'b1;
    es = 32'd1000;
    eq = 32'd7;
    for (int r = 0; r < TO; r++) mt[r] = 1'b0;
    run("ramp", 1'b0);
    chk("change_count", change_count, 16'd9);
    ramp = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
